// File: rtl/stride_loop_counter.sv
// stride_loop_counter: runtime start/limit/step loop index generator.
// Up or down stride, stall, abort, auto-repeat, exit value and trip count.
module stride_loop_counter #(
  parameter int WIDTH  = 4,
  parameter int ITER_W = WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              en,
  input  logic [WIDTH-1:0]  cfg_start,
  input  logic [WIDTH-1:0]  cfg_limit,
  input  logic [WIDTH-1:0]  cfg_step,
  input  logic              cfg_down,
  input  logic              cfg_repeat,
  output logic              busy,
  output logic              valid,
  output logic [WIDTH-1:0]  index,
  output logic              last,
  output logic              done,
  output logic [WIDTH:0]    exit_value,
  output logic [ITER_W-1:0] iter_count,
  output logic              err
);

  localparam int NW = WIDTH + 2;
  localparam logic signed [NW-1:0] IDX_MAX =
    {2'b00, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  logic [WIDTH-1:0]  sh_start;
  logic [WIDTH-1:0]  sh_limit;
  logic [WIDTH-1:0]  sh_step;
  logic              sh_down;
  logic              sh_repeat;
  logic [ITER_W-1:0] cnt;

  logic signed [NW-1:0] idx_x;
  logic signed [NW-1:0] lim_x;
  logic signed [NW-1:0] stp_x;
  logic signed [NW-1:0] rst_x;
  logic signed [NW-1:0] cs_x;
  logic signed [NW-1:0] cl_x;
  logic signed [NW-1:0] nxt;
  logic                 cont;
  logic                 first_ok;
  logic                 rerun_ok;

  // Out-of-range values fail regardless of limit, so the index never wraps.
  function automatic logic holds(
    input logic signed [NW-1:0] v,
    input logic signed [NW-1:0] lim,
    input logic                 dn
  );
    logic in_rng;
    in_rng = !v[NW-1] && (v <= IDX_MAX);
    return in_rng && (dn ? (v > lim) : (v < lim));
  endfunction

  assign idx_x = {2'b00, index};
  assign lim_x = {2'b00, sh_limit};
  assign stp_x = {2'b00, sh_step};
  assign rst_x = {2'b00, sh_start};
  assign cs_x  = {2'b00, cfg_start};
  assign cl_x  = {2'b00, cfg_limit};

  assign nxt = sh_down ? (idx_x - stp_x)
                       : (idx_x + stp_x);

  assign cont     = holds(nxt, lim_x, sh_down);
  assign first_ok = holds(cs_x, cl_x, cfg_down);
  assign rerun_ok = holds(rst_x, lim_x, sh_down);

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign valid = (state == S_RUN) && en && !abort;
  assign last  = valid && !cont;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sh_start   <= '0;
      sh_limit   <= '0;
      sh_step    <= '0;
      sh_down    <= 1'b0;
      sh_repeat  <= 1'b0;
      cnt        <= '0;
      index      <= '0;
      exit_value <= '0;
      iter_count <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (cfg_step == '0) begin
              err <= 1'b1;
            end else begin
              sh_start  <= cfg_start;
              sh_limit  <= cfg_limit;
              sh_step   <= cfg_step;
              sh_down   <= cfg_down;
              sh_repeat <= cfg_repeat;
              index     <= cfg_start;
              cnt       <= '0;
              if (first_ok) begin
                state <= S_RUN;
              end else begin
                state      <= S_DONE;
                exit_value <= {1'b0, cfg_start};
                iter_count <= '0;
              end
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (en) begin
            cnt <= cnt + 1'b1;
            if (cont) begin
              index <= nxt[WIDTH-1:0];
            end else begin
              state      <= S_DONE;
              exit_value <= nxt[WIDTH:0];
              iter_count <= cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          // An empty loop never re-enters RUN, even with repeat set.
          if (!abort && sh_repeat && rerun_ok) begin
            state <= S_RUN;
            index <= sh_start;
            cnt   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stride_loop_counter.sv
// tb_stride_loop_counter: directed and randomized loops checked
// against a plain for-loop reference model.
module tb_stride_loop_counter;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic         abort;
  logic         en;
  logic [W-1:0] cfg_start;
  logic [W-1:0] cfg_limit;
  logic [W-1:0] cfg_step;
  logic         cfg_down;
  logic         cfg_repeat;
  logic         busy;
  logic         valid;
  logic [W-1:0] index;
  logic         last;
  logic         done;
  logic [W:0]   exit_value;
  logic [W:0]   iter_count;
  logic         err;

  stride_loop_counter #(.WIDTH(W), .ITER_W(W + 1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .en         (en),
    .cfg_start  (cfg_start),
    .cfg_limit  (cfg_limit),
    .cfg_step   (cfg_step),
    .cfg_down   (cfg_down),
    .cfg_repeat (cfg_repeat),
    .busy       (busy),
    .valid      (valid),
    .index      (index),
    .last       (last),
    .done       (done),
    .exit_value (exit_value),
    .iter_count (iter_count),
    .err        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int exp_q[$];
  int exp_exit;
  int exp_cnt;

  int obs_q[$];
  int obs_last[$];
  int stall_idx[$];
  int done_cyc;
  int last_cyc;
  int o_exit;
  int o_cnt;
  int busy0;

  // Reference: the software loop, with the exit value as 5-bit two's complement.
  function automatic void model(input int s, input int l,
                                input int st, input bit dn);
    int i;
    exp_q.delete();
    i = s;
    while (dn ? (i > l) : (i < l)) begin
      exp_q.push_back(i);
      i = dn ? i - st : i + st;
    end
    exp_exit = i & 31;
    exp_cnt  = exp_q.size();
  endfunction

  function automatic string q2s(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  function automatic bit last_ok();
    int n;
    n = 0;
    foreach (obs_last[i]) n += obs_last[i];
    if (obs_last.size() == 0) return n == 0;
    return n == 1 && obs_last[obs_last.size() - 1] == 1;
  endfunction

  task automatic set_cfg(input int s, input int l, input int st,
                         input bit dn, input bit rp);
    cfg_start  = s[W-1:0];
    cfg_limit  = l[W-1:0];
    cfg_step   = st[W-1:0];
    cfg_down   = dn;
    cfg_repeat = rp;
  endtask

  // mode 0: en=1, 1: random en, 2: en pattern 1,0,0,1,1...
  task automatic drive_loop(input int s, input int l, input int st,
                            input bit dn, input int mode,
                            input bit poke);
    int cyc;
    obs_q.delete();
    obs_last.delete();
    stall_idx.delete();
    done_cyc = -1;
    last_cyc = -1;
    @(negedge clk);
    set_cfg(s, l, st, dn, 1'b0);
    start = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy0 = int'(busy);
    cyc = 0;
    while (done_cyc < 0 && cyc < 200) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = 1'($urandom_range(0, 1));
        default: en = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
      endcase
      if (poke && cyc == 2) begin
        start = 1'b1;
        set_cfg(0, 15, 1, 1'b0, 1'b1);
      end else begin
        start = 1'b0;
      end
      #1;
      if (valid) begin
        obs_q.push_back(int'(index));
        obs_last.push_back(int'(last));
        last_cyc = cyc;
      end else if (busy && !done) begin
        stall_idx.push_back(int'(index));
      end
      if (done) begin
        done_cyc = cyc;
        o_exit   = int'(exit_value);
        o_cnt    = int'(iter_count);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    en    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, valid, last, done, err, index, exit_value,
         iter_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b valid=%b last=%b done=%b err=%b idx=%0d exit=%0d cnt=%0d want all 0",
               busy, valid, last, done, err, index, exit_value, iter_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_up();
    model(2, 14, 2, 1'b0);
    drive_loop(2, 14, 2, 1'b0, 0, 1'b0);
    n_cmp++;
    if (q2s(obs_q) != q2s(exp_q)) begin
      n_bad++;
      $display("FAIL up_seq got %s want %s", q2s(obs_q), q2s(exp_q));
    end
    n_cmp++;
    if (o_exit != 14 || o_cnt != 6) begin
      n_bad++;
      $display("FAIL up_exit got exit=%0d cnt=%0d want 14/6", o_exit, o_cnt);
    end
    n_cmp++;
    if (!last_ok() || done_cyc != 6) begin
      n_bad++;
      $display("FAIL up_last_done got last_ok=%0d done_cyc=%0d want 1/6",
               last_ok(), done_cyc);
    end
    #1;
    n_cmp++;
    if (busy0 != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL up_busy got busy0=%0d after=%b want 1/0", busy0, busy);
    end
  endtask

  task automatic test_down();
    model(13, 1, 3, 1'b1);
    drive_loop(13, 1, 3, 1'b1, 0, 1'b0);
    n_cmp++;
    if (q2s(obs_q) != q2s(exp_q) || o_exit != exp_exit ||
        o_cnt != exp_cnt) begin
      n_bad++;
      $display("FAIL down_seq got %s exit=%0d cnt=%0d want %s exit=%0d cnt=%0d",
               q2s(obs_q), o_exit, o_cnt, q2s(exp_q), exp_exit, exp_cnt);
    end
    model(2, 0, 3, 1'b1);
    drive_loop(2, 0, 3, 1'b1, 0, 1'b0);
    n_cmp++;
    if (q2s(obs_q) != "2 " || o_exit != 31 || o_cnt != 1) begin
      n_bad++;
      $display("FAIL down_underflow got %s exit=%0d cnt=%0d want 2 /31/1",
               q2s(obs_q), o_exit, o_cnt);
    end
    n_cmp++;
    if (!last_ok() || done_cyc != last_cyc + 1) begin
      n_bad++;
      $display("FAIL down_last got last_ok=%0d done_cyc=%0d want 1/%0d",
               last_ok(), done_cyc, last_cyc + 1);
    end
  endtask

  task automatic test_bounds();
    model(12, 15, 4, 1'b0);
    drive_loop(12, 15, 4, 1'b0, 0, 1'b0);
    n_cmp++;
    if (q2s(obs_q) != q2s(exp_q) || o_exit != 16 || o_cnt != 1) begin
      n_bad++;
      $display("FAIL overflow got %s exit=%0d cnt=%0d want %s 16/1",
               q2s(obs_q), o_exit, o_cnt, q2s(exp_q));
    end
    model(14, 14, 2, 1'b0);
    drive_loop(14, 14, 2, 1'b0, 0, 1'b0);
    n_cmp++;
    if (obs_q.size() != 0 || done_cyc != 0 || o_exit != 14 ||
        o_cnt != 0) begin
      n_bad++;
      $display("FAIL empty got n=%0d done_cyc=%0d exit=%0d cnt=%0d want 0/0/14/0",
               obs_q.size(), done_cyc, o_exit, o_cnt);
    end
    #1;
    n_cmp++;
    if (busy0 != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_busy got busy0=%0d after=%b want 1/0", busy0, busy);
    end
  endtask

  task automatic test_err();
    @(negedge clk);
    set_cfg(3, 9, 0, 1'b0, 1'b0);
    start = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || exit_value !== 5'(exp_exit)) begin
      n_bad++;
      $display("FAIL err_pulse got err=%b busy=%b exit=%0d want 1/0/%0d",
               err, busy, exit_value, exp_exit);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear got err=%b busy=%b want 0/0", err, busy);
    end
    en = 1'b0;
  endtask

  task automatic test_busy_start();
    model(2, 14, 2, 1'b0);
    drive_loop(2, 14, 2, 1'b0, 0, 1'b1);
    n_cmp++;
    if (q2s(obs_q) != q2s(exp_q) || o_exit != exp_exit ||
        o_cnt != exp_cnt) begin
      n_bad++;
      $display("FAIL busy_start got %s exit=%0d cnt=%0d want %s %0d/%0d",
               q2s(obs_q), o_exit, o_cnt, q2s(exp_q), exp_exit, exp_cnt);
    end
  endtask

  task automatic test_stall();
    model(2, 14, 2, 1'b0);
    drive_loop(2, 14, 2, 1'b0, 2, 1'b0);
    n_cmp++;
    if (q2s(obs_q) != q2s(exp_q) || o_exit != exp_exit ||
        o_cnt != exp_cnt) begin
      n_bad++;
      $display("FAIL stall_seq got %s exit=%0d cnt=%0d want %s %0d/%0d",
               q2s(obs_q), o_exit, o_cnt, q2s(exp_q), exp_exit, exp_cnt);
    end
    n_cmp++;
    if (q2s(stall_idx) != "4 4 " || done_cyc != 8) begin
      n_bad++;
      $display("FAIL stall_hold got held=%s done_cyc=%0d want 4 4 /8",
               q2s(stall_idx), done_cyc);
    end
  endtask

  task automatic test_repeat();
    int cyc;
    int ndone;
    int dc[2];
    string want;
    model(2, 14, 2, 1'b0);
    want = {q2s(exp_q), q2s(exp_q)};
    obs_q.delete();
    ndone = 0;
    dc[0] = -1;
    dc[1] = -1;
    @(negedge clk);
    set_cfg(2, 14, 2, 1'b0, 1'b1);
    start = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (ndone < 2 && cyc < 100) begin
      #1;
      if (valid) obs_q.push_back(int'(index));
      if (done) begin
        dc[ndone] = cyc;
        ndone++;
      end
      @(negedge clk);
      cyc++;
    end
    #1;
    n_cmp++;
    if (q2s(obs_q) != want || dc[0] != 6 || dc[1] != 13) begin
      n_bad++;
      $display("FAIL repeat_seq got %s done@%0d,%0d want %s done@6,13",
               q2s(obs_q), dc[0], dc[1], want);
    end
    n_cmp++;
    if (valid !== 1'b1 || index !== 4'd2) begin
      n_bad++;
      $display("FAIL repeat_reload got valid=%b idx=%0d want 1/2", valid, index);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || exit_value !== 5'd14 ||
        iter_count !== 5'd6) begin
      n_bad++;
      $display("FAIL repeat_abort got busy=%b done=%b exit=%0d cnt=%0d want 0/0/14/6",
               busy, done, exit_value, iter_count);
    end
    en = 1'b0;
  endtask

  task automatic test_abort();
    int saw_done;
    model(5, 15, 1, 1'b0);
    drive_loop(5, 15, 1, 1'b0, 1, 1'b0);
    saw_done = 0;
    @(negedge clk);
    set_cfg(1, 15, 1, 1'b0, 1'b0);
    start = 1'b1;
    en    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      saw_done += int'(done);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || saw_done != 0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_run got busy=%b done_seen=%0d want 0/0", busy, saw_done);
    end
    n_cmp++;
    if (exit_value !== 5'(exp_exit) || iter_count !== 5'(exp_cnt)) begin
      n_bad++;
      $display("FAIL abort_keep got exit=%0d cnt=%0d want %0d/%0d",
               exit_value, iter_count, exp_exit, exp_cnt);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_start_idle got busy=%b err=%b want 0/0", busy, err);
    end
    en = 1'b0;
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    set_cfg(3, 15, 2, 1'b0, 1'b1);
    start = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, valid, last, done, err, index, exit_value,
         iter_count} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid got busy=%b valid=%b done=%b idx=%0d exit=%0d cnt=%0d want all 0",
               busy, valid, done, index, exit_value, iter_count);
    end
    rst   = 1'b0;
    start = 1'b0;
    en    = 1'b0;
  endtask

  task automatic test_random();
    int s;
    int l;
    int st;
    bit dn;
    for (int k = 0; k < 30; k++) begin
      s  = int'($urandom_range(0, 15));
      l  = int'($urandom_range(0, 15));
      st = int'($urandom_range(1, 15));
      dn = 1'($urandom_range(0, 1));
      model(s, l, st, dn);
      drive_loop(s, l, st, dn, 1, 1'b0);
      n_cmp++;
      if (q2s(obs_q) != q2s(exp_q) || o_exit != exp_exit ||
          o_cnt != exp_cnt) begin
        n_bad++;
        $display("FAIL rand%0d s=%0d l=%0d st=%0d dn=%0d got %s %0d/%0d want %s %0d/%0d",
                 k, s, l, st, dn, q2s(obs_q), o_exit, o_cnt,
                 q2s(exp_q), exp_exit, exp_cnt);
      end
      n_cmp++;
      if (!last_ok() || done_cyc != last_cyc + 1) begin
        n_bad++;
        $display("FAIL rand%0d_last got last_ok=%0d done_cyc=%0d want 1/%0d",
                 k, last_ok(), done_cyc, last_cyc + 1);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    en    = 1'b0;
    set_cfg(0, 0, 0, 1'b0, 1'b0);
    test_reset();
    test_up();
    test_down();
    test_bounds();
    test_err();
    test_busy_start();
    test_stall();
    test_repeat();
    test_abort();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
